// File: rtl/axis_timing_scheduler.sv
// axis_timing_scheduler: time-shares a single calc_time engine across N_CH
// motion channels in ascending index order. Each enabled channel's parameters
// are presented to the engine, and its timing words are collected into a flat
// output bank. Supports a per-move channel mask, abort, and an engine-timeout
// error path.
module axis_timing_scheduler #(
   parameter int N_CH    = 5,
   parameter int N_PARAM = 5,
   parameter int P_W     = 32,
   parameter int N_TIM   = 4,
   parameter int T_W     = 64,
   parameter int GAP     = 20,
   parameter int TIMEOUT = 65535
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     start,
   input  logic                                     abort,
   input  logic [N_CH-1:0]                          ch_en,
   input  logic [N_CH*N_PARAM*P_W-1:0]              params_flat,
   output logic                                     ct_start,
   output logic [N_PARAM*P_W-1:0]                   ct_params,
   input  logic [N_TIM*T_W-1:0]                     ct_timing,
   input  logic                                     ct_finish,
   output logic [N_CH*N_TIM*T_W-1:0]                timing_flat,
   output logic [N_CH-1:0]                          ch_done,
   output logic                                     busy,
   output logic                                     finish,
   output logic                                     error,
   output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] err_ch
);

   localparam int IDX_W = $clog2(N_CH + 1);
   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int TC_W  = $clog2(TIMEOUT + 1);
   localparam int GC_W  = $clog2(GAP + 1);
   localparam int PS_W  = N_PARAM * P_W;
   localparam int TS_W  = N_TIM * T_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SCAN,
      ST_LOAD,
      ST_RUN,
      ST_CAPTURE,
      ST_GAP,
      ST_DONE,
      ST_ERR
   } state_t;

   state_t            state;
   logic [IDX_W-1:0]  idx;
   logic [CH_W-1:0]   idx_c;
   logic [N_CH-1:0]   ch_en_q;
   logic [TC_W-1:0]   tcnt;
   logic [GC_W-1:0]   gcnt;

   // idx runs up to N_CH; the narrowed copy is only used once idx < N_CH
   assign idx_c = idx[CH_W-1:0];

   // Sequencer: state, counters and all registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         idx         <= '0;
         ch_en_q     <= '0;
         tcnt        <= '0;
         gcnt        <= '0;
         ct_start    <= 1'b0;
         ct_params   <= '0;
         timing_flat <= '0;
         ch_done     <= '0;
         busy        <= 1'b0;
         finish      <= 1'b0;
         error       <= 1'b0;
         err_ch      <= '0;
      end else if (abort) begin
         state    <= ST_IDLE;
         ct_start <= 1'b0;
         busy     <= 1'b0;
         finish   <= 1'b0;
         error    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  ch_en_q     <= ch_en;
                  ch_done     <= '0;
                  timing_flat <= '0;
                  idx         <= '0;
                  busy        <= 1'b1;
                  finish      <= 1'b0;
                  state       <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (idx == IDX_W'(N_CH)) begin
                  busy   <= 1'b0;
                  finish <= 1'b1;
                  state  <= ST_DONE;
               end else if (!ch_en_q[idx_c]) begin
                  ch_done[idx_c] <= 1'b1;
                  idx            <= idx + IDX_W'(1);
               end else begin
                  // parameters are registered on entry to LOAD so they are
                  // stable for the whole cycle before ct_start rises
                  ct_params <= params_flat[int'(idx_c) * PS_W +: PS_W];
                  state     <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               tcnt     <= '0;
               ct_start <= 1'b1;
               state    <= ST_RUN;
            end
            ST_RUN: begin
               if (ct_finish) begin
                  state <= ST_CAPTURE;
               end else if (tcnt == TC_W'(TIMEOUT - 1)) begin
                  ct_start <= 1'b0;
                  busy     <= 1'b0;
                  error    <= 1'b1;
                  err_ch   <= idx_c;
                  state    <= ST_ERR;
               end else begin
                  tcnt <= tcnt + TC_W'(1);
               end
            end
            ST_CAPTURE: begin
               timing_flat[int'(idx_c) * TS_W +: TS_W] <= ct_timing;
               ch_done[idx_c] <= 1'b1;
               ct_start       <= 1'b0;
               gcnt           <= GC_W'(GAP);
               state          <= ST_GAP;
            end
            ST_GAP: begin
               if (gcnt == '0) begin
                  if (!ct_finish) begin
                     idx   <= idx + IDX_W'(1);
                     state <= ST_SCAN;
                  end
               end else begin
                  gcnt <= gcnt - GC_W'(1);
               end
            end
            ST_ERR: begin
               state <= ST_ERR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axis_timing_scheduler.sv
// Testbench for axis_timing_scheduler: randomized moves against a cycle-count
// and result-bank reference model, with a queue-based scoreboard and monitor.
module tb_axis_timing_scheduler;

   localparam int N_CH    = 5;
   localparam int N_PARAM = 5;
   localparam int P_W     = 32;
   localparam int N_TIM   = 4;
   localparam int T_W     = 64;
   localparam int GAP     = 20;
   localparam int TIMEOUT = 100;
   localparam int STALL   = 1000;
   localparam int PS_W    = N_PARAM * P_W;
   localparam int TS_W    = N_TIM * T_W;
   localparam int TF_W    = N_CH * TS_W;

   logic                      clk = 1'b0;
   logic                      reset;
   logic                      start;
   logic                      abort;
   logic [N_CH-1:0]           ch_en;
   logic [N_CH*PS_W-1:0]      params_flat;
   logic                      ct_start;
   logic [PS_W-1:0]           ct_params;
   logic [TS_W-1:0]           ct_timing;
   logic                      ct_finish;
   logic [TF_W-1:0]           timing_flat;
   logic [N_CH-1:0]           ch_done;
   logic                      busy;
   logic                      finish;
   logic                      error;
   logic [2:0]                err_ch;

   axis_timing_scheduler #(
      .N_CH(N_CH), .N_PARAM(N_PARAM), .P_W(P_W), .N_TIM(N_TIM),
      .T_W(T_W), .GAP(GAP), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .ch_en(ch_en),
      .params_flat(params_flat), .ct_start(ct_start), .ct_params(ct_params),
      .ct_timing(ct_timing), .ct_finish(ct_finish), .timing_flat(timing_flat),
      .ch_done(ch_done), .busy(busy), .finish(finish), .error(error),
      .err_ch(err_ch)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   // stimulus-side world: channel parameters and engine behaviour per channel
   logic [P_W-1:0] prm [N_CH][N_PARAM];
   int             eng_lat  [N_CH];
   int             eng_hold [N_CH];

   always_comb begin
      params_flat = '0;
      for (int i = 0; i < N_CH; i++)
         for (int k = 0; k < N_PARAM; k++)
            params_flat[(i*N_PARAM+k)*P_W +: P_W] = prm[i][k];
   end

   // engine model: finishes in the eng_lat-th cycle of ct_start, optionally
   // keeps ct_finish stuck high for eng_hold cycles after ct_start drops
   int   run_cnt;
   int   hold_cnt;
   int   eng_ch;
   logic fin_raw;

   always_comb begin
      eng_ch = int'(ct_params[3:0]);
      if (eng_ch >= N_CH) eng_ch = 0;
      fin_raw   = ct_start && (run_cnt >= eng_lat[eng_ch] - 1);
      ct_finish = fin_raw || (hold_cnt != 0);
      ct_timing = '0;
      for (int k = 0; k < N_TIM; k++)
         ct_timing[k*T_W +: T_W] = {ct_params[k*P_W +: P_W], 32'hA500_0000 | 32'(k)};
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         run_cnt  <= 0;
         hold_cnt <= 0;
      end else begin
         run_cnt <= ct_start ? run_cnt + 1 : 0;
         if (fin_raw)
            hold_cnt <= eng_hold[eng_ch];
         else if (hold_cnt != 0)
            hold_cnt <= hold_cnt - 1;
      end
   end

   // scoreboard
   typedef struct {
      bit              is_err;
      int              lat;
      logic [N_CH-1:0] done;
      int              ech;
      logic [TF_W-1:0] tim;
   } exp_t;

   exp_t exp_q[$];
   int   load_q[$];
   exp_t last_exp;
   int   start_cyc = 0;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
      end
   endfunction

   function automatic logic [T_W-1:0] tword(input int i, input int k);
      return {prm[i][k], 32'hA500_0000 | 32'(k)};
   endfunction

   // reference model: walk the channels and add up cycle costs
   task automatic model(input logic [N_CH-1:0] mask, input bit push_final);
      exp_t e;
      int   c;
      c        = 1;
      e.is_err = 1'b0;
      e.lat    = 0;
      e.done   = '0;
      e.ech    = 0;
      e.tim    = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (!mask[i]) begin
            e.done[i] = 1'b1;
            c += 1;
         end else begin
            load_q.push_back(i);
            if (eng_lat[i] > TIMEOUT) begin
               e.is_err = 1'b1;
               e.ech    = i;
               e.lat    = c + 2 + TIMEOUT;
               break;
            end
            for (int k = 0; k < N_TIM; k++)
               e.tim[(i*N_TIM+k)*T_W +: T_W] = tword(i, k);
            e.done[i] = 1'b1;
            c += 4 + eng_lat[i] + ((eng_hold[i] > GAP) ? eng_hold[i] : GAP);
         end
      end
      if (!e.is_err) e.lat = c + 1;
      if (push_final) exp_q.push_back(e);
      last_exp = e;
   endtask

   // monitor
   logic            fin_d = 1'b0;
   logic            err_d = 1'b0;
   logic            cs_d  = 1'b0;
   logic [PS_W-1:0] prm_d = '0;
   int              mon_ch;
   exp_t            mon_e;

   always @(negedge clk) begin
      if (reset) begin
         fin_d = 1'b0;
         err_d = 1'b0;
         cs_d  = 1'b0;
         prm_d = '0;
      end else begin
         if (ct_start && !cs_d) begin
            if (load_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_load: ct_start rose with no load expected (cycle %0d)", cyc);
            end else begin
               mon_ch = load_q.pop_front();
               for (int k = 0; k < N_PARAM; k++) begin
                  chk($sformatf("ct_params_ch%0d_w%0d", mon_ch, k),
                      64'(ct_params[k*P_W +: P_W]), 64'(prm[mon_ch][k]));
                  chk($sformatf("ct_params_early_ch%0d_w%0d", mon_ch, k),
                      64'(prm_d[k*P_W +: P_W]), 64'(prm[mon_ch][k]));
               end
            end
         end
         if ((finish && !fin_d) || (error && !err_d)) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_end: finish=%0b error=%0b with nothing expected (cycle %0d)",
                        finish, error, cyc);
            end else begin
               mon_e = exp_q.pop_front();
               chk("end_kind_error", 64'(error), 64'(mon_e.is_err));
               chk("end_latency", 64'(cyc - start_cyc), 64'(mon_e.lat));
               chk("end_ch_done", 64'(ch_done), 64'(mon_e.done));
               chk("end_busy", 64'(busy), 64'd0);
               if (mon_e.is_err) chk("end_err_ch", 64'(err_ch), 64'(mon_e.ech));
               for (int w = 0; w < N_CH*N_TIM; w++)
                  chk($sformatf("timing_word%0d", w),
                      timing_flat[w*T_W +: T_W], mon_e.tim[w*T_W +: T_W]);
            end
         end
         fin_d = finish;
         err_d = error;
         cs_d  = ct_start;
         prm_d = ct_params;
      end
   end

   task automatic set_params();
      for (int i = 0; i < N_CH; i++) begin
         for (int k = 0; k < N_PARAM; k++) prm[i][k] = $urandom;
         prm[i][0][3:0] = 4'(i);
      end
   endtask

   task automatic go(input logic [N_CH-1:0] mask, input bit push_final);
      @(negedge clk);
      model(mask, push_final);
      ch_en     = mask;
      start     = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
      ch_en = N_CH'($urandom);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("wait_budget_left", 64'(exp_q.size()), 64'd0);
      chk("loads_left", 64'(load_q.size()), 64'd0);
      exp_q.delete();
      load_q.delete();
   endtask

   task automatic abort_pulse(input string tag);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk({tag, "_error"}, 64'(error), 64'd0);
      chk({tag, "_finish"}, 64'(finish), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_ct_start"}, 64'(ct_start), 64'd0);
   endtask

   task automatic chk_bank(input string tag, input logic [N_CH-1:0] cap);
      chk({tag, "_ch_done"}, 64'(ch_done), 64'(cap));
      for (int i = 0; i < N_CH; i++)
         for (int k = 0; k < N_TIM; k++)
            chk($sformatf("%s_slice%0d_w%0d", tag, i, k),
                timing_flat[(i*N_TIM+k)*T_W +: T_W], cap[i] ? tword(i, k) : '0);
   endtask

   task automatic wait_for(input string tag, input logic [N_CH-1:0] need_done, input int budget);
      int n;
      n = 0;
      while (!(ct_start && ((ch_done & need_done) == need_done)) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_reached"}, 64'(n < budget), 64'd1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ct_start"}, 64'(ct_start), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_finish"}, 64'(finish), 64'd0);
      chk({tag, "_error"}, 64'(error), 64'd0);
      chk({tag, "_ch_done"}, 64'(ch_done), 64'd0);
      chk({tag, "_err_ch"}, 64'(err_ch), 64'd0);
      chk({tag, "_ct_params_any"}, 64'(|ct_params), 64'd0);
      chk({tag, "_timing_any"}, 64'(|timing_flat), 64'd0);
   endtask

   initial begin
      #900_000;
      n_err++;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [N_CH-1:0] mask;
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      ch_en = '0;
      set_params();
      for (int i = 0; i < N_CH; i++) begin
         eng_lat[i]  = 10;
         eng_hold[i] = 0;
      end
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      reset = 1'b0;
      @(negedge clk);

      // all channels, 10-cycle engine: finish at 5*(14+20)+2
      go(5'b11111, 1'b1);
      wait_idle(2000);
      // sparse mask
      set_params();
      go(5'b10100, 1'b1);
      wait_idle(2000);
      // empty mask
      go(5'b00000, 1'b1);
      wait_idle(100);
      // stale ct_finish stretches GAP
      eng_hold[0] = 30;
      go(5'b00011, 1'b1);
      wait_idle(2000);
      eng_hold[0] = 0;

      // engine stall on channel 1
      eng_lat[1] = STALL;
      go(5'b11111, 1'b1);
      wait_idle(1000);
      @(negedge clk);
      start = 1'b1;
      ch_en = '1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("err_hold_error", 64'(error), 64'd1);
      chk("err_hold_busy", 64'(busy), 64'd0);
      chk("err_hold_err_ch", 64'(err_ch), 64'd1);
      chk("err_hold_ct_start", 64'(ct_start), 64'd0);
      abort_pulse("err_abort");
      chk_bank("err_abort", 5'b00001);
      eng_lat[1] = 10;

      // randomized moves
      for (int r = 0; r < 10; r++) begin
         set_params();
         for (int i = 0; i < N_CH; i++) begin
            eng_lat[i] = $urandom_range(1, 12);
            if ($urandom_range(0, 7) == 0) eng_lat[i] = TIMEOUT;
            if ($urandom_range(0, 11) == 0) eng_lat[i] = STALL;
            eng_hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(GAP - 3, GAP + 10) : 0;
         end
         mask = N_CH'($urandom);
         go(mask, 1'b1);
         if (last_exp.lat > 40) begin
            repeat (10) @(negedge clk);
            start = 1'b1;
            ch_en = ~mask;
            @(negedge clk);
            start = 1'b0;
         end
         wait_idle(3000);
         if (last_exp.is_err) abort_pulse("rand_abort");
      end

      for (int i = 0; i < N_CH; i++) begin
         eng_lat[i]  = 10;
         eng_hold[i] = 0;
      end
      set_params();

      // asynchronous reset while the engine is running
      go(5'b11111, 1'b0);
      wait_for("rst_run", 5'b00001, 200);
      @(negedge clk);
      #2 reset = 1'b1;
      #1 chk_reset_outputs("mid_reset");
      exp_q.delete();
      load_q.delete();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // abort while the engine is running drops ct_start
      go(5'b00001, 1'b0);
      wait_for("abort_run", 5'b00000, 50);
      abort_pulse("abort_run");
      load_q.delete();
      repeat (5) @(negedge clk);

      // abort together with start during GAP: abort wins, bank preserved
      go(5'b00011, 1'b0);
      begin
         int n;
         n = 0;
         while (!ch_done[0] && n < 100) begin
            @(negedge clk);
            n++;
         end
         chk("abort_gap_reached", 64'(n < 100), 64'd1);
      end
      abort = 1'b1;
      start = 1'b1;
      ch_en = '1;
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      chk("abort_gap_ct_start", 64'(ct_start), 64'd0);
      chk("abort_gap_busy", 64'(busy), 64'd0);
      chk("abort_gap_finish", 64'(finish), 64'd0);
      chk_bank("abort_gap", 5'b00001);
      load_q.delete();
      repeat (5) @(negedge clk);
      chk("abort_beats_start_busy", 64'(busy), 64'd0);
      chk("abort_beats_start_ct", 64'(ct_start), 64'd0);
      chk("abort_after_load_q", 64'(load_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/axis_timing_scheduler.md
# axis_timing_scheduler

Parametrised sequencer that time-shares one `calc_time` engine across N motion channels (X, Y, Z, E0, E1 by default) and collects each channel's phase timings into a flat output bank. It sits between the G-code move decoder and the per-axis step generators, and replaces the fixed five-axis sequencer. It adds a per-move channel-enable mask, a start/finish handshake, abort, and an engine-timeout error path.

## Interface
- `N_CH`, 5, number of channels; channel i is serviced in ascending index order
- `N_PARAM`, 5, parameter words per channel
- `P_W`, 32, parameter word width
- `N_TIM`, 4, timing words returned per channel
- `T_W`, 64, timing word width
- `GAP`, 20, idle cycles inserted after each capture (≥1)
- `TIMEOUT`, 65535, maximum RUN cycles per channel before error (≥1)

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state and outputs
- `start`  in  1  single-cycle request; sampled only in IDLE or DONE
- `abort`  in  1  synchronous; returns to IDLE from any state, highest priority after reset
- `ch_en`  in  N_CH  channel mask, latched at accepted `start`
- `params_flat`  in  N_CH*N_PARAM*P_W  channel i word k at bits [(i*N_PARAM+k)*P_W +: P_W]
- `ct_start`  out  1  engine start, level
- `ct_params`  out  N_PARAM*P_W  registered parameters for the current channel
- `ct_timing`  in  N_TIM*T_W  engine result
- `ct_finish`  in  1  engine done, level
- `timing_flat`  out  N_CH*N_TIM*T_W  channel i word k at [(i*N_TIM+k)*T_W +: T_W]
- `ch_done`  out  N_CH  bit i set when channel i has been captured or skipped
- `busy`  out  1  high in all states except IDLE, DONE and ERR
- `finish`  out  1  high in DONE
- `error`  out  1  high in ERR
- `err_ch`  out  $clog2(N_CH)  channel that timed out

## Operation
- States: IDLE, SCAN, LOAD, RUN, CAPTURE, GAP, DONE, ERR.
- IDLE/DONE + `start`: latch `ch_en`, clear `ch_done`, clear `timing_flat`, set idx=0, go to SCAN.
- SCAN: if idx==N_CH, go to DONE. Else if `ch_en[idx]`=0, set `ch_done[idx]`, idx++, stay in SCAN (one channel per cycle). Else go to LOAD.
- LOAD: register `params_flat` slice idx into `ct_params`, clear timeout counter, go to RUN.
- RUN: `ct_start`=1 and the counter increments. On `ct_finish`=1, go to CAPTURE. If the counter reaches TIMEOUT first, go to ERR with `err_ch`=idx.
- CAPTURE: store `ct_timing` into slice idx, set `ch_done[idx]`, drop `ct_start`, load the gap counter with GAP, go to GAP.
- GAP: decrement. Leave only when the counter is 0 and `ct_finish`=0; then idx++ and go to SCAN. A stale `ct_finish` extends GAP indefinitely (no timeout here).
- DONE: `finish`=1, outputs hold. Stays until `start` or `abort`.
- ERR: `error`=1, `ct_start`=0, outputs hold. Exit only by `abort` or `reset`; `start` is ignored.
- `abort`: go to IDLE and force `ct_start`=0. `timing_flat` and `ch_done` hold their values; `finish` and `error` clear.
- `ch_en`=0 at start: scan all channels, then DONE with `ch_done` all ones and timings zero.
- Counters use widths $clog2(TIMEOUT+1) and $clog2(GAP+1). No wrap-around is possible.

## Timing
- Reset values: state IDLE, all outputs 0 (`ct_params`, `timing_flat`, `ch_done`, `err_ch`, `busy`, `finish`, `error`, `ct_start`).
- `start` accepted at edge 0: SCAN in cycle 1, LOAD in cycle 2, `ct_start` high from cycle 3.
- `ct_params` is valid the cycle before `ct_start` rises and stays stable until the next LOAD.
- `ct_finish` high at edge t: CAPTURE in t+1. `ct_start` is low and `timing_flat` updated from edge t+2.
- Per enabled channel: 4 + engine latency + GAP cycles. Per skipped channel: 1 cycle.
- `start` and `abort` in the same cycle: `abort` wins.
- `ct_finish` and the timeout in the same cycle: `ct_finish` wins.
- `start` outside IDLE/DONE is ignored.
- Reset mid-RUN: `ct_start` drops asynchronously.

## Test plan
- Mask 5'b11111, engine model with 10-cycle latency returning {i,k}-tagged words → `timing_flat` slices match, `finish` rises 5*(14+20)+2 cycles after `start`.
- Mask 5'b10100 → only channels 2 and 4 are loaded. `ch_done`=5'b11111; slices 0, 1, 3 are 0.
- Mask 0 → `finish` at cycle 1+5+1 after `start`, `ct_start` never asserted.
- Engine stalls on channel 1 with TIMEOUT=100 → `error`=1 and `err_ch`=1 after 100 RUN cycles; `start` is ignored; `abort` returns to IDLE.
- `ct_finish` held high 30 cycles after the drop of `ct_start`, GAP=20 → the next LOAD waits until `ct_finish` falls.
- `reset` asserted mid-RUN, then `abort` mid-GAP on a second run → all outputs return to reset values; `abort` drops `ct_start` and preserves captured slices.
